// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage pipeline controller for a 5-stage core.
//
// The block keeps a shadow copy of the EX/MEM/WB destinations. From it, it
// decides each cycle whether the instruction in ID issues, stalls or is
// flushed. It also sequences the illegal-instruction trap through four
// states: RUN -> DRAIN -> TRAP -> HALT.
//
// Build option ID_FORWARD_EN:
//   defined   : only load-use stalls are taken; fwd_rs1/fwd_rs2 select the
//               MEM (01) or WB (10) bypass for the instruction in EX.
//   undefined : full RAW interlock against EX, MEM and WB; fwd_* tied to 00.
//
// Handshake: there is no valid/ready pair. if_valid qualifies the ID fields
// for the current cycle. An instruction leaves ID only in a cycle where
// issue=1. While stall_id=1 the fetch side must hold the IF/ID contents.
// While flush=1 the IF/ID contents are discarded.
//
// dbg_o = {state[1:0], ex_v, mem_v, wb_v, ex_is_load}, for observation only.

`timescale 1ns/1ps

module id_hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int CNT_SAT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             if_valid,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_ill,
   input  logic             ex_redirect,
   input  logic             mem_stall,
   input  logic             restart,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush,
   output logic             issue,
   output logic [1:0]       fwd_rs1,
   output logic [1:0]       fwd_rs2,
   output logic             trap,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [5:0]       dbg_o
);

   localparam logic [6:0]       OP_LOAD = 7'b0000011;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_TRAP  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             ex_v_q, mem_v_q, wb_v_q;
   logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q;
   // Only the EX copy of is_load is needed: load-use is detected against EX alone.
   logic             ex_ld_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             hazard;
   logic             cnt_inc;

   // Register x0 is never a producer, so rd==0 never matches a source.
   function automatic logic src_hit(input logic v, input logic [4:0] rd,
                                    input logic [4:0] rs);
      return v && (rd != 5'd0) && (rd == rs);
   endfunction

   function automatic logic rd_hit(input logic v, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
      return src_hit(v, rd, rs1) || src_hit(v, rd, rs2);
   endfunction

   // Hazard detection against the shadow stages.
`ifdef ID_FORWARD_EN
   always_comb begin
      hazard = ex_v_q && ex_ld_q && rd_hit(1'b1, ex_rd_q, id_rs1, id_rs2);
   end
`else
   always_comb begin
      hazard = rd_hit(ex_v_q,  ex_rd_q,  id_rs1, id_rs2) ||
               rd_hit(mem_v_q, mem_rd_q, id_rs1, id_rs2) ||
               rd_hit(wb_v_q,  wb_rd_q,  id_rs1, id_rs2);
   end
`endif

   // Control decision and FSM next state. Priority: freeze > redirect > illegal > hazard > issue.
   always_comb begin
      state_d  = state_q;
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush    = 1'b0;
      issue    = 1'b0;
      trap     = 1'b0;
      cnt_inc  = 1'b0;
      if (!reset_n) begin
         state_d = S_RUN;
      end else if (mem_stall) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else begin
         case (state_q)
            S_RUN: begin
               if (ex_redirect) begin
                  flush = 1'b1;
               end else if (if_valid && id_ill) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  state_d  = S_DRAIN;
               end else if (if_valid && hazard) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  cnt_inc  = 1'b1;
               end else if (if_valid) begin
                  issue = 1'b1;
               end
            end
            S_DRAIN: begin
               if (ex_redirect) begin
                  flush   = 1'b1;
                  state_d = S_RUN;
               end else begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  // Registered valids already reflect the previous shift.
                  if (!ex_v_q && !mem_v_q && !wb_v_q) state_d = S_TRAP;
               end
            end
            S_TRAP: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               trap     = 1'b1;
               state_d  = S_HALT;
            end
            S_HALT: begin
               if (restart) begin
                  flush   = 1'b1;
                  state_d = S_RUN;
               end else begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // Shadow pipeline, FSM state and stall counter; everything holds during a freeze.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_RUN;
         ex_v_q      <= 1'b0;
         mem_v_q     <= 1'b0;
         wb_v_q      <= 1'b0;
         ex_rd_q     <= 5'd0;
         mem_rd_q    <= 5'd0;
         wb_rd_q     <= 5'd0;
         ex_ld_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else if (!mem_stall) begin
         state_q  <= state_d;
         ex_v_q   <= issue;
         ex_rd_q  <= issue ? id_rd : 5'd0;
         ex_ld_q  <= issue && (id_opcode == OP_LOAD);
         mem_v_q  <= ex_v_q;
         mem_rd_q <= ex_rd_q;
         wb_v_q   <= mem_v_q;
         wb_rd_q  <= mem_rd_q;
         if (cnt_inc) begin
            if (stall_cnt_q == CNT_MAX)
               stall_cnt_q <= (CNT_SAT != 0) ? CNT_MAX : '0;
            else
               stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
      end
   end

`ifdef ID_FORWARD_EN
   logic [1:0] fwd_rs1_q, fwd_rs1_d;
   logic [1:0] fwd_rs2_q, fwd_rs2_d;

   // The current EX enters MEM and the current MEM enters WB at the issue edge; MEM wins.
   function automatic logic [1:0] fwd_sel(input logic ev, input logic [4:0] erd,
                                          input logic mv, input logic [4:0] mrd,
                                          input logic [4:0] rs);
      if (src_hit(ev, erd, rs))      return 2'b01;
      else if (src_hit(mv, mrd, rs)) return 2'b10;
      else                           return 2'b00;
   endfunction

   // Forward selects for the instruction entering EX; a bubble gets 00.
   always_comb begin
      fwd_rs1_d = 2'b00;
      fwd_rs2_d = 2'b00;
      if (issue) begin
         fwd_rs1_d = fwd_sel(ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, id_rs1);
         fwd_rs2_d = fwd_sel(ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, id_rs2);
      end
   end

   // Forward select registers travel with the instruction into EX.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fwd_rs1_q <= 2'b00;
         fwd_rs2_q <= 2'b00;
      end else if (!mem_stall) begin
         fwd_rs1_q <= fwd_rs1_d;
         fwd_rs2_q <= fwd_rs2_d;
      end
   end

   assign fwd_rs1 = fwd_rs1_q;
   assign fwd_rs2 = fwd_rs2_q;
`else
   assign fwd_rs1 = 2'b00;
   assign fwd_rs2 = 2'b00;
`endif

   assign halted    = reset_n && (state_q == S_HALT);
   assign stall_cnt = stall_cnt_q;
   assign dbg_o     = {state_q, ex_v_q, mem_v_q, wb_v_q, ex_ld_q};

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Testbench for id_hazard_ctrl. Directed cycle vectors with hand-computed
// expected outputs are queued by the driver and checked by a negedge monitor.
// Two extra instances with CNT_W=4 (saturating and wrapping) share the inputs.

`timescale 1ns/1ps

module tb_id_hazard_ctrl;

  localparam logic [6:0] OP_ALU = 7'h33;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_BAD = 7'h7F;

  // side-band stimulus bits {reset, redirect, mem_stall, restart}
  localparam logic [3:0] SD_NONE = 4'b0000;
  localparam logic [3:0] SD_RST  = 4'b1000;
  localparam logic [3:0] SD_RED  = 4'b0100;
  localparam logic [3:0] SD_MS   = 4'b0010;
  localparam logic [3:0] SD_RS   = 4'b0001;

  localparam logic [1:0] ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_TRAP = 2'd2, ST_HALT = 2'd3;

  // {stall_if, stall_id, flush, issue}
  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_ISS  = 4'b0001;
  localparam logic [3:0] C_STL  = 4'b1100;
  localparam logic [3:0] C_FLS  = 4'b0010;

  // {trap, halted}
  localparam logic [1:0] TH_NONE = 2'b00, TH_TRAP = 2'b10, TH_HALT = 2'b01;

  localparam int W = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       if_valid = 1'b0;
  logic [6:0] id_opcode = 7'h0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_ill = 1'b0, ex_redirect = 1'b0, mem_stall = 1'b0, restart = 1'b0;

  logic        stall_if, stall_id, flush, issue, trap, halted;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [31:0] stall_cnt;
  logic [5:0]  dbg_o;

  logic        s_stall_if, s_stall_id, s_flush, s_issue, s_trap, s_halted;
  logic [1:0]  s_fwd_rs1, s_fwd_rs2;
  logic [3:0]  s_cnt;
  logic [5:0]  s_dbg;

  logic        w_stall_if, w_stall_id, w_flush, w_issue, w_trap, w_halted;
  logic [1:0]  w_fwd_rs1, w_fwd_rs2;
  logic [3:0]  w_cnt;
  logic [5:0]  w_dbg;

  id_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ill(id_ill),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall), .restart(restart),
    .stall_if(stall_if), .stall_id(stall_id), .flush(flush), .issue(issue),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .trap(trap), .halted(halted),
    .stall_cnt(stall_cnt), .dbg_o(dbg_o)
  );

  id_hazard_ctrl #(.CNT_W(4), .CNT_SAT(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ill(id_ill),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall), .restart(restart),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .flush(s_flush), .issue(s_issue),
    .fwd_rs1(s_fwd_rs1), .fwd_rs2(s_fwd_rs2), .trap(s_trap), .halted(s_halted),
    .stall_cnt(s_cnt), .dbg_o(s_dbg)
  );

  id_hazard_ctrl #(.CNT_W(4), .CNT_SAT(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ill(id_ill),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall), .restart(restart),
    .stall_if(w_stall_if), .stall_id(w_stall_id), .flush(w_flush), .issue(w_issue),
    .fwd_rs1(w_fwd_rs1), .fwd_rs2(w_fwd_rs2), .trap(w_trap), .halted(w_halted),
    .stall_cnt(w_cnt), .dbg_o(w_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  // expected vector: {state, ctl, fwd1, fwd2, trap, halted, cnt[7:0], sat4, wrap4}
  function automatic logic [W-1:0] make_exp(input logic [1:0] st, input logic [3:0] ctl,
                                            input logic [3:0] f, input logic [1:0] th,
                                            input int cnt);
    logic [7:0] c8;
    logic [3:0] sat;
    logic [3:0] wrp;
    c8  = cnt[7:0];
    sat = (cnt > 15) ? 4'd15 : c8[3:0];
    wrp = c8[3:0];
    return {st, ctl, f, th, c8, sat, wrp};
  endfunction

  // Monitor: one queued vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {dbg_o[5:4], stall_if, stall_id, flush, issue, fwd_rs1, fwd_rs2,
             trap, halted, stall_cnt[7:0], s_cnt, w_cnt};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h (st,ctl,fwd,trap/halt,cnt,sat,wrap)", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [6:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd, input logic ill,
                     input logic [3:0] side, input logic [1:0] st, input logic [3:0] ctl,
                     input logic [3:0] f, input logic [1:0] th, input int cnt,
                     input string nm);
    @(posedge clk);
    #1;
    reset_n     = ~side[3];
    ex_redirect = side[2];
    mem_stall   = side[1];
    restart     = side[0];
    if_valid    = v;
    id_opcode   = op;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_ill      = ill;
    exp_q.push_back(make_exp(st, ctl, f, th, cnt));
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [3:0] f, input int cnt, input string nm);
    cyc(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, SD_NONE, ST_RUN, C_IDLE, f, TH_NONE, cnt, nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0; if_valid = 1'b0; id_ill = 1'b0;
    ex_redirect = 1'b0; mem_stall = 1'b0; restart = 1'b0;
    cyc(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, SD_RST, ST_RUN, C_IDLE, 4'h0, TH_NONE, 0, "reset_state");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    int n;
    int per;
    logic iss;
    logic [3:0] f;

    // T1: add x5 ; add x6,x5,x1
    do_reset();
`ifdef ID_FORWARD_EN
    cyc(1, OP_ALU, 5'd1, 5'd2, 5'd5, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t1_prod");
    cyc(1, OP_ALU, 5'd5, 5'd1, 5'd6, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t1_cons");
    idle(4'b0100, 0, "t1_fwd_mem");
    idle(4'b0000, 0, "t1_fwd_clear");
`else
    cyc(1, OP_ALU, 5'd1, 5'd2, 5'd5, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t1_prod");
    cyc(1, OP_ALU, 5'd5, 5'd1, 5'd6, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t1_stall_ex");
    cyc(1, OP_ALU, 5'd5, 5'd1, 5'd6, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 1, "t1_stall_mem");
    cyc(1, OP_ALU, 5'd5, 5'd1, 5'd6, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 2, "t1_stall_wb");
    cyc(1, OP_ALU, 5'd5, 5'd1, 5'd6, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 3, "t1_cons");
    idle(4'b0000, 3, "t1_cnt");
`endif

    // T2: lw x7 ; add x8,x7,x7
    do_reset();
    cyc(1, OP_LD, 5'd1, 5'd0, 5'd7, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t2_load");
`ifdef ID_FORWARD_EN
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t2_loaduse");
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 1, "t2_issue");
    idle(4'b1010, 1, "t2_fwd_wb");
    idle(4'b0000, 1, "t2_fwd_clear");
    // MEM bypass wins when EX and MEM both write x9
    do_reset();
    cyc(1, OP_ALU, 5'd0, 5'd0, 5'd9, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t2b_p1");
    cyc(1, OP_ALU, 5'd0, 5'd0, 5'd9, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t2b_p2");
    cyc(1, OP_ALU, 5'd9, 5'd0, 5'd10, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t2b_cons");
    idle(4'b0100, 0, "t2b_mem_wins");
`else
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t2_stall1");
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 1, "t2_stall2");
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 2, "t2_stall3");
    cyc(1, OP_ALU, 5'd7, 5'd7, 5'd8, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 3, "t2_issue");
    idle(4'b0000, 3, "t2_cnt");
`endif

    // T3: redirect beats a load-use hazard; redirect drops an illegal instruction
    do_reset();
    cyc(1, OP_LD,  5'd1, 5'd0, 5'd7, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t3_load");
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_RED,  ST_RUN, C_FLS, 4'h0, TH_NONE, 0, "t3_flush");
    idle(4'b0000, 0, "t3_cnt_same");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_RED,  ST_RUN, C_FLS, 4'h0, TH_NONE, 0, "t3_ill_flush");
    idle(4'b0000, 0, "t3_no_trap");

    // T4: illegal behind two in-flight ALU ops, trap, halt, restart
    do_reset();
    cyc(1, OP_ALU, 5'd0, 5'd0, 5'd1, 0, SD_NONE, ST_RUN,   C_ISS, 4'h0, TH_NONE, 0, "t4_alu1");
    cyc(1, OP_ALU, 5'd0, 5'd0, 5'd2, 0, SD_NONE, ST_RUN,   C_ISS, 4'h0, TH_NONE, 0, "t4_alu2");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_RUN,   C_STL, 4'h0, TH_NONE, 0, "t4_detect");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_DRAIN, C_STL, 4'h0, TH_NONE, 0, "t4_drain1");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_DRAIN, C_STL, 4'h0, TH_NONE, 0, "t4_drain2");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_DRAIN, C_STL, 4'h0, TH_NONE, 0, "t4_drain3");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_TRAP,  C_STL, 4'h0, TH_TRAP, 0, "t4_trap");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_HALT,  C_STL, 4'h0, TH_HALT, 0, "t4_halt");
    cyc(0, OP_ALU, 5'd0, 5'd0, 5'd0, 0, SD_RS,   ST_HALT,  C_FLS, 4'h0, TH_HALT, 0, "t4_restart");
    cyc(0, OP_ALU, 5'd0, 5'd0, 5'd0, 0, SD_RS,   ST_RUN,   C_IDLE, 4'h0, TH_NONE, 0, "t4_restart_ignored");

    // T4b: redirect from an older instruction aborts the drain
    do_reset();
    cyc(1, OP_ALU, 5'd0, 5'd0, 5'd1, 0, SD_NONE, ST_RUN,   C_ISS, 4'h0, TH_NONE, 0, "t4b_alu");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE, ST_RUN,   C_STL, 4'h0, TH_NONE, 0, "t4b_detect");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_RED,  ST_DRAIN, C_FLS, 4'h0, TH_NONE, 0, "t4b_redirect");
    idle(4'b0000, 0, "t4b_back_to_run");

    // T5: freeze for 4 cycles in the middle of a load-use stall
    do_reset();
    cyc(1, OP_LD, 5'd1, 5'd0, 5'd7, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 0, "t5_load");
    for (int i = 0; i < 4; i++)
      cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_MS, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t5_freeze");
`ifdef ID_FORWARD_EN
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t5_hazard");
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 1, "t5_issue");
    idle(4'b1000, 1, "t5_fwd_wb");
`else
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 0, "t5_stall1");
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 1, "t5_stall2");
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_STL, 4'h0, TH_NONE, 2, "t5_stall3");
    cyc(1, OP_ALU, 5'd7, 5'd0, 5'd8, 0, SD_NONE, ST_RUN, C_ISS, 4'h0, TH_NONE, 3, "t5_issue");
    idle(4'b0000, 3, "t5_cnt");
`endif

    // T7: reset during a freeze while draining loses the pending trap
    do_reset();
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_NONE,       ST_RUN,   C_STL,  4'h0, TH_NONE, 0, "t7_detect");
    cyc(1, OP_BAD, 5'd0, 5'd0, 5'd0, 1, SD_RST | SD_MS, ST_DRAIN, C_IDLE, 4'h0, TH_NONE, 0, "t7_reset_out");
    idle(4'b0000, 0, "t7_after_reset");
    idle(4'b0000, 0, "t7_no_trap");

    // T6: back-to-back dependent loads x5 <- [x5]; 20 hazard cycles total
    do_reset();
`ifdef ID_FORWARD_EN
    n = 40; per = 2;
`else
    n = 27; per = 4;
`endif
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      iss = ((k % per) == 0);
`ifdef ID_FORWARD_EN
      f = ((k % 2) == 1 && k >= 3) ? 4'b1000 : 4'b0000;
`else
      f = 4'b0000;
`endif
      cyc(1, OP_LD, 5'd5, 5'd0, 5'd5, 0, SD_NONE, ST_RUN, iss ? C_ISS : C_STL, f, TH_NONE,
          stalls, "t6_chain");
      if (!iss) stalls++;
    end
    idle(4'b0000, stalls, "t6_final_cnt");

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
